// File: rtl/alu_pkg.sv
// Shared opcode/state types and the legality rule for the ALU input sequencer.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_MOD = 4'd4,
      OP_AND = 4'd5,
      OP_OR  = 4'd6,
      OP_XOR = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } seq_state_t;

   localparam logic [3:0] OP_LAST = 4'd9;

   // Divide and modulo by zero are rejected along with undefined opcodes.
   function automatic logic op_is_legal(input logic [3:0] op, input logic b_is_zero);
      return (op <= OP_LAST) &&
             !(b_is_zero && ((op == OP_DIV) || (op == OP_MOD)));
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Synchronises a raw push-button and emits a registered one-cycle pulse per press.
module btn_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   pulse_q, pulse_d;

   always_comb begin
      sync_d[0] = btn_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d  = sync_q[SYNC_STAGES-1];
      pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   // Reset loads "pressed" so a button already held through reset yields no pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Button-driven operand/opcode capture for the ALU with latched result and error display.
// state  | meaning
// S_A    | waiting for operand A press
// S_B    | waiting for operand B press
// S_OP   | waiting for opcode press
// S_EXEC | one settle cycle for the ALU on registered operands
// S_SHOW | result displayed until next press
module alu_input_sequencer
   import alu_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   sw_data,
   input  logic           btn_next,
   input  logic           btn_clear,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   output logic [3:0]     alu_op,
   input  logic [2*N-1:0] alu_result,
   input  logic [3:0]     alu_flags,
   output logic [2*N-1:0] result_q,
   output logic [3:0]     flags_q,
   output logic           result_valid,
   output logic           error,
   output logic [2:0]     stage
);

   logic next_pulse, clear_pulse;

   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_next (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_next),
      .pulse   (next_pulse)
   );

   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clear),
      .pulse   (clear_pulse)
   );

   seq_state_t     state_q, state_d;
   logic [N-1:0]   alu_a_q, alu_a_d;
   logic [N-1:0]   alu_b_q, alu_b_d;
   logic [3:0]     alu_op_q, alu_op_d;
   logic [2*N-1:0] res_q, res_d;
   logic [3:0]     flg_q, flg_d;
   logic           valid_q, valid_d;
   logic           error_q, error_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_A;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_A:     if (next_pulse) state_d = S_B;
         S_B:     if (next_pulse) state_d = S_OP;
         S_OP:    if (next_pulse) state_d = S_EXEC;
         S_EXEC:  state_d = S_SHOW;
         S_SHOW:  if (next_pulse) state_d = S_A;
         default: state_d = S_A;
      endcase
      if (clear_pulse) state_d = S_A;
   end

   always_comb begin
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      res_d    = res_q;
      flg_d    = flg_q;
      valid_d  = valid_q;
      error_d  = error_q;
      case (state_q)
         S_A:  if (next_pulse) alu_a_d  = sw_data;
         S_B:  if (next_pulse) alu_b_d  = sw_data;
         S_OP: if (next_pulse) alu_op_d = sw_data[3:0];
         S_EXEC: begin
            if (op_is_legal(alu_op_q, alu_b_q == '0)) begin
               res_d   = alu_result;
               flg_d   = alu_flags;
               error_d = 1'b0;
            end else begin
               res_d   = '0;
               flg_d   = '0;
               error_d = 1'b1;
            end
            valid_d = 1'b1;
         end
         S_SHOW: if (next_pulse) valid_d = 1'b0;
         default: ;
      endcase
      if (clear_pulse) begin
         alu_a_d  = '0;
         alu_b_d  = '0;
         alu_op_d = '0;
         res_d    = '0;
         flg_d    = '0;
         valid_d  = 1'b0;
         error_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         res_q    <= '0;
         flg_q    <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         res_q    <= res_d;
         flg_q    <= flg_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign result_q     = res_q;
   assign flags_q      = flg_q;
   assign result_valid = valid_q;
   assign error        = error_q;
   assign stage        = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench: behavioural sequencer model compared every cycle, plus directed literal checks.
module tb_alu_input_sequencer;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   sw_data;
   logic           btn_next, btn_clear;
   logic [N-1:0]   alu_a, alu_b;
   logic [3:0]     alu_op;
   logic [2*N-1:0] alu_result;
   logic [3:0]     alu_flags;
   logic [2*N-1:0] result_q;
   logic [3:0]     flags_q;
   logic           result_valid, error;
   logic [2:0]     stage;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_input_sequencer #(.N(N), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .sw_data      (sw_data),
      .btn_next     (btn_next),
      .btn_clear    (btn_clear),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_flags    (alu_flags),
      .result_q     (result_q),
      .flags_q      (flags_q),
      .result_valid (result_valid),
      .error        (error),
      .stage        (stage)
   );

   // Reference ALU: returns {result[7:0], N, Z, C, V}.
   function automatic logic [11:0] alu_calc(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] op);
      logic [7:0] r;
      logic       c, v;
      r = 8'd0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin r = {4'd0, a} + {4'd0, b}; c = r[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
         4'd1: begin r = {4'd0, a} - {4'd0, b}; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
         4'd2: r = {4'd0, a} * {4'd0, b};
         4'd3: r = (b == 4'd0) ? 8'd0 : {4'd0, a / b};
         4'd4: r = (b == 4'd0) ? 8'd0 : {4'd0, a % b};
         4'd5: r = {4'd0, a & b};
         4'd6: r = {4'd0, a | b};
         4'd7: r = {4'd0, a ^ b};
         4'd8: r = {4'd0, a} << b;
         4'd9: r = {4'd0, a >> b};
         default: r = 8'd0;
      endcase
      return {r, r[7], (r == 8'd0), c, v};
   endfunction

   assign {alu_result, alu_flags} = alu_calc(alu_a, alu_b, alu_op);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a press is seen by the sequencer 3 clock edges after its first
   // sampled high level; reset treats the button as already pressed.
   int         m_stage;
   logic [3:0] m_a, m_b, m_op, m_fl;
   logic [7:0] m_res;
   bit         m_valid, m_err;
   bit         hn[4] = '{1, 1, 1, 1};
   bit         hc[4] = '{1, 1, 1, 1};
   bit         last_rst = 1'b1;
   bit         started = 1'b0;

   always @(negedge clk) begin
      bit          pn, pc, legal;
      logic [11:0] calc;
      if (started) begin
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_op", alu_op, m_op);
         chk("result_q", result_q, m_res);
         chk("flags_q", flags_q, m_fl);
         chk("result_valid", result_valid, m_valid);
         chk("error", error, m_err);
         chk("stage", stage, m_stage);
      end
      pn = last_rst ? 1'b0 : (hn[2] & ~hn[3]);
      pc = last_rst ? 1'b0 : (hc[2] & ~hc[3]);
      if (rst || pc) begin
         m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_fl = 0;
         m_valid = 0; m_err = 0;
      end else begin
         case (m_stage)
            0: if (pn) begin m_a  = sw_data;      m_stage = 1; end
            1: if (pn) begin m_b  = sw_data;      m_stage = 2; end
            2: if (pn) begin m_op = sw_data[3:0]; m_stage = 3; end
            3: begin
               legal = !((m_op > 4'd9) || (((m_op == 4'd3) || (m_op == 4'd4)) && (m_b == 4'd0)));
               calc  = alu_calc(m_a, m_b, m_op);
               if (legal) begin m_res = calc[11:4]; m_fl = calc[3:0]; m_err = 0; end
               else       begin m_res = 0;          m_fl = 0;         m_err = 1; end
               m_valid = 1;
               m_stage = 4;
            end
            default: if (pn) begin m_valid = 0; m_stage = 0; end
         endcase
      end
      for (int i = 3; i > 0; i--) begin
         hn[i] = hn[i-1];
         hc[i] = hc[i-1];
      end
      hn[0] = btn_next;
      hc[0] = btn_clear;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            hn[i] = 1'b1;
            hc[i] = 1'b1;
         end
         started = 1'b1;
      end
      last_rst = rst;
   end

   task automatic press(input bit nxt, input bit clr, input logic [3:0] d, input int hold);
      @(posedge clk); #1;
      sw_data   = d;
      btn_next  = nxt;
      btn_clear = clr;
      repeat (hold) @(posedge clk);
      #1;
      btn_next  = 1'b0;
      btn_clear = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   task automatic seq3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      press(1, 0, a, 5);
      press(1, 0, b, 5);
      press(1, 0, op, 5);
   endtask

   initial begin
      logic [11:0] exp_calc;
      int          r;
      rst = 1'b1; btn_next = 1'b1; btn_clear = 1'b0; sw_data = 4'h0;

      // Reset with next held across the release
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1 btn_next = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("rst_stage", stage, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_result", result_q, 0);

      // ADD
      seq3(4'b0110, 4'b1001, 4'b0000);
      @(negedge clk);
      exp_calc = alu_calc(4'b0110, 4'b1001, 4'b0000);
      chk("add_alu_a", alu_a, 4'b0110);
      chk("add_alu_b", alu_b, 4'b1001);
      chk("add_result", result_q, 8'h0F);
      chk("add_model_result", m_res, 8'h0F);
      chk("add_flags", flags_q, exp_calc[3:0]);
      chk("add_valid", result_valid, 1);
      chk("add_error", error, 0);
      chk("add_stage", stage, 4);
      press(1, 0, 4'h0, 5);

      // DIV by zero
      seq3(4'b1101, 4'b0000, 4'b0011);
      @(negedge clk);
      chk("div0_result", result_q, 0);
      chk("div0_flags", flags_q, 0);
      chk("div0_error", error, 1);
      chk("div0_valid", result_valid, 1);
      press(1, 0, 4'h0, 5);
      @(negedge clk);
      chk("div0_ack_stage", stage, 0);
      chk("div0_ack_valid", result_valid, 0);
      chk("div0_ack_error", error, 1);

      // Illegal opcode, then MUL
      seq3(4'b0011, 4'b0001, 4'b1010);
      @(negedge clk);
      chk("illegal_error", error, 1);
      chk("illegal_result", result_q, 0);
      press(1, 0, 4'h0, 5);
      seq3(4'b1111, 4'b1111, 4'b0010);
      @(negedge clk);
      chk("mul_result", result_q, 8'hE1);
      chk("mul_model_result", m_res, 8'hE1);
      chk("mul_error", error, 0);
      press(1, 0, 4'h0, 5);

      // Long hold advances once; simultaneous next+clear in S_B clears
      press(1, 0, 4'h5, 40);
      @(negedge clk);
      chk("hold_stage", stage, 1);
      chk("hold_alu_a", alu_a, 4'h5);
      press(1, 1, 4'h7, 5);
      @(negedge clk);
      chk("clr_stage", stage, 0);
      chk("clr_alu_a", alu_a, 0);

      // One-cycle reset while in S_OP
      press(1, 0, 4'hA, 5);
      press(1, 0, 4'h3, 5);
      @(negedge clk);
      chk("pre_rst_stage", stage, 2);
      chk("pre_rst_alu_a", alu_a, 4'hA);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst1_stage", stage, 0);
      chk("rst1_alu_a", alu_a, 0);
      chk("rst1_valid", result_valid, 0);
      seq3(4'h2, 4'h3, 4'h0);
      @(negedge clk);
      chk("post_rst_result", result_q, 8'h05);
      chk("post_rst_valid", result_valid, 1);
      press(1, 0, 4'h0, 5);

      // Randomised traffic
      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            @(posedge clk); #1 rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 rst = 1'b0;
         end else if (r < 3) begin
            press(0, 1, 4'($urandom_range(0, 15)), $urandom_range(5, 9));
         end else if (r == 3) begin
            press(1, 1, 4'($urandom_range(0, 15)), $urandom_range(5, 9));
         end else begin
            press(1, 0, 4'($urandom_range(0, 15)), $urandom_range(5, 9));
         end
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
